// File: rtl/adc_scan_ctrl_if.sv
// rtl/adc_scan_ctrl_if.sv - Gowin_ADC side signals of the scan sequencer
interface adc_scan_ctrl_if;
    logic        adc_clk;
    logic        adc_en;
    logic        adc_mode;
    logic [2:0]  adc_vsenctl;
    logic        adc_req;
    logic        adc_rdy;
    logic [13:0] adc_value;

    modport master (
        output adc_clk, adc_en, adc_mode, adc_vsenctl, adc_req,
        input  adc_rdy, adc_value
    );

    modport slave (
        input  adc_clk, adc_en, adc_mode, adc_vsenctl, adc_req,
        output adc_rdy, adc_value
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - multi-channel scan sequencer for the GW5A Gowin_ADC macro
// Optional per-visit sample averaging is enabled by defining ADC_SCAN_AVG_EN.
module adc_scan_ctrl #(
    parameter int NUM_CH       = 8,
    parameter int CLK_DIV_LOG2 = 5,
    parameter int SETTLE_CYC   = 256,
    parameter int TIMEOUT_CYC  = 65535,
    parameter int AVG_LOG2     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start,
    input  logic                cont,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [NUM_CH-1:0]   temp_mask,
    adc_scan_ctrl_if.master     adc,
    output logic                res_valid,
    output logic [2:0]          res_ch,
    output logic [13:0]         res_data,
    input  logic [2:0]          rd_ch,
    output logic [13:0]         rd_data,
    output logic                busy,
    output logic                scan_done,
    output logic [NUM_CH-1:0]   timeout_err
);

`ifdef ADC_SCAN_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    localparam int AVG_SH = AVG_EN ? AVG_LOG2 : 0;
    localparam int ACC_W  = 14 + AVG_SH;
    localparam int NSAMP  = 1 << AVG_SH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEL    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_CAPT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    logic [CLK_DIV_LOG2:0] clk_count;
    logic                  rdy_s1, rdy_s2, rdy_s3;
    logic                  rdy_rise;
    logic                  en_q;

    logic [2:0]            state;
    logic [NUM_CH-1:0]     pending;
    logic [2:0]            cur_ch;
    logic [31:0]           cnt;
    logic [31:0]           samp_cnt;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic                  last_samp;
    logic [13:0]           sample_res;
    logic                  mode_q;
    logic [2:0]            vsen_q;
    logic                  req_q;
    logic [13:0]           bank [8];

    logic [2:0]            sel_idx;
    logic [NUM_CH-1:0]     sel_oh;
    logic [NUM_CH-1:0]     cur_oh;

    // Free-running divider and adcrdy synchroniser; nothing here depends on FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_count <= '0;
            rdy_s1    <= 1'b0;
            rdy_s2    <= 1'b0;
            rdy_s3    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            clk_count <= clk_count + 1'b1;
            rdy_s1    <= adc.adc_rdy;
            rdy_s2    <= rdy_s1;
            rdy_s3    <= rdy_s2;
            en_q      <= en;
        end
    end

    assign rdy_rise = rdy_s2 & ~rdy_s3;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = 3'(i);
        end
    end

    assign sel_oh     = NUM_CH'(1) << sel_idx;
    assign cur_oh     = NUM_CH'(1) << cur_ch;
    assign acc_sum    = acc + ACC_W'(adc.adc_value);
    assign last_samp  = (samp_cnt == 32'(NSAMP - 1));
    assign sample_res = 14'(acc_sum >> AVG_SH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= '0;
            cur_ch      <= '0;
            cnt         <= '0;
            samp_cnt    <= '0;
            acc         <= '0;
            mode_q      <= 1'b1;
            vsen_q      <= '0;
            req_q       <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_data    <= '0;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
            timeout_err <= '0;
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
                req_q <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start || cont) begin
                            pending     <= ch_mask;
                            timeout_err <= '0;
                            if (ch_mask == '0) begin
                                scan_done <= 1'b1;
                            end else begin
                                busy  <= 1'b1;
                                state <= S_SEL;
                            end
                        end
                    end
                    S_SEL: begin
                        cur_ch   <= sel_idx;
                        vsen_q   <= sel_idx;
                        mode_q   <= ~|(temp_mask & sel_oh);
                        pending  <= pending & ~sel_oh;
                        cnt      <= '0;
                        samp_cnt <= '0;
                        acc      <= '0;
                        state    <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt == 32'(SETTLE_CYC - 1)) begin
                            cnt   <= '0;
                            req_q <= 1'b1;
                            state <= S_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (rdy_rise) begin
                            req_q    <= 1'b0;
                            cnt      <= '0;
                            samp_cnt <= samp_cnt + 1'b1;
                            state    <= S_CAPT;
                            if (last_samp) begin
                                bank[cur_ch] <= sample_res;
                                res_ch       <= cur_ch;
                                res_data     <= sample_res;
                                res_valid    <= 1'b1;
                            end else begin
                                acc <= acc_sum;
                            end
                        end else if (cnt == 32'(TIMEOUT_CYC - 1)) begin
                            req_q       <= 1'b0;
                            timeout_err <= timeout_err | cur_oh;
                            state       <= S_NEXT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_CAPT: begin
                        // Re-request without settling until the visit has all its samples.
                        if (samp_cnt == 32'(NSAMP)) begin
                            state <= S_NEXT;
                        end else begin
                            req_q <= 1'b1;
                            state <= S_REQ;
                        end
                    end
                    S_NEXT: begin
                        if (pending != '0) begin
                            state <= S_SEL;
                        end else begin
                            scan_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign rd_data         = ({1'b0, rd_ch} < 4'(NUM_CH)) ? bank[rd_ch] : '0;
    assign adc.adc_clk     = clk_count[CLK_DIV_LOG2];
    assign adc.adc_en      = en_q;
    assign adc.adc_mode    = mode_q;
    assign adc.adc_vsenctl = vsen_q;
    assign adc.adc_req     = req_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - directed bench for adc_scan_ctrl with a behavioural ADC model
`timescale 1ns/1ps
module tb_adc_scan_ctrl;
    localparam int NUM_CH = 6;
`ifdef ADC_SCAN_AVG_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [NUM_CH-1:0] temp_mask = '0;
    logic              res_valid;
    logic [2:0]        res_ch;
    logic [13:0]       res_data;
    logic [2:0]        rd_ch = '0;
    logic [13:0]       rd_data;
    logic              busy;
    logic              scan_done;
    logic [NUM_CH-1:0] timeout_err;

    adc_scan_ctrl_if ifc();

    adc_scan_ctrl #(
        .NUM_CH(NUM_CH), .CLK_DIV_LOG2(1), .SETTLE_CYC(4), .TIMEOUT_CYC(40), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont),
        .ch_mask(ch_mask), .temp_mask(temp_mask), .adc(ifc),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .scan_done(scan_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ADC model: answers each request two cycles later, holds adcrdy until adcreq drops.
    int          model_on = 0;
    logic [13:0] model_val [8];
    int          glitch_req = 0;
    int          glitch_seen = 0;
    int          pulses = 0;
    int          seq_base = 0;
    int          seq_len = 0;
    logic [13:0] seq [4];
    time         rdy_t = 0;

    initial begin
        ifc.adc_rdy   = 1'b0;
        ifc.adc_value = '0;
        forever begin
            @(negedge clk);
            if (glitch_req != glitch_seen) begin
                glitch_seen = glitch_req;
                ifc.adc_rdy = 1'b1;
                repeat (4) @(negedge clk);
                ifc.adc_rdy = 1'b0;
            end else if (model_on != 0 && ifc.adc_req) begin
                repeat (2) @(negedge clk);
                if (pulses - seq_base < seq_len) ifc.adc_value = seq[pulses - seq_base];
                else                             ifc.adc_value = model_val[ifc.adc_vsenctl];
                pulses++;
                ifc.adc_rdy = 1'b1;
                rdy_t = $time;
                for (int k = 0; k < 16 && ifc.adc_req; k++) @(negedge clk);
                ifc.adc_rdy = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
    end

    int          n_valid = 0;
    int          n_done = 0;
    int          n_req = 0;
    logic        req_prev = 1'b0;
    logic [2:0]  log_ch [$];
    logic [13:0] log_data [$];
    logic [2:0]  log_vsen [$];
    logic        log_mode [$];
    time         valid_t = 0;

    always @(negedge clk) begin
        if (res_valid) begin
            n_valid++;
            log_ch.push_back(res_ch);
            log_data.push_back(res_data);
            valid_t = $time;
        end
        if (scan_done) n_done++;
        if (ifc.adc_req && !req_prev) begin
            n_req++;
            log_vsen.push_back(ifc.adc_vsenctl);
            log_mode.push_back(ifc.adc_mode);
        end
        req_prev = ifc.adc_req;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!scan_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic [NUM_CH-1:0] temp;
        logic [13:0]       val;
        logic [2:0]        ch;
        logic              mode;
    } vec_t;

    vec_t vt [6];

    initial begin
        int          b_v, b_r, b_d, k, c, nd;
        logic [13:0] prev_rd;

        vt[0] = '{6'h01, 6'h00, 14'h0001, 3'd0, 1'b1};
        vt[1] = '{6'h20, 6'h20, 14'h3FFF, 3'd5, 1'b0};
        vt[2] = '{6'h10, 6'h01, 14'h2AAA, 3'd4, 1'b1};
        vt[3] = '{6'h08, 6'h3F, 14'h1001, 3'd3, 1'b0};
        vt[4] = '{6'h02, 6'h3D, 14'h0777, 3'd1, 1'b1};
        vt[5] = '{6'h01, 6'h01, 14'h1555, 3'd0, 1'b0};
        for (int i = 0; i < 8; i++) model_val[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_adc_mode", 32'(ifc.adc_mode), 32'd1);
        check("rst_adc_req", 32'(ifc.adc_req), 32'd0);
        check("rst_adc_vsenctl", 32'(ifc.adc_vsenctl), 32'd0);
        check("rst_adc_clk", 32'(ifc.adc_clk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            check($sformatf("rst_rd_data_ch%0d", i), 32'(rd_data), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Divider: adc_clk = bit 1 of a counter that starts at 0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("adc_clk_%0d", i), 32'(ifc.adc_clk), 32'(((i + 1) >> 1) & 1));
        end

        en = 1'b1;
        model_on = 1;
        @(negedge clk);
        check("adc_en_follows_en", 32'(ifc.adc_en), 32'd1);

        // Single-channel vectors
        for (int i = 0; i < 6; i++) begin
            model_val[vt[i].ch] = vt[i].val;
            ch_mask = vt[i].mask;
            temp_mask = vt[i].temp;
            b_v = n_valid; b_r = n_req; b_d = n_done;
            pulse_start();
            wait_done($sformatf("vec%0d_done_in_time", i), 400);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_valid_count", i), 32'(n_valid - b_v), 32'd1);
            check($sformatf("vec%0d_res_ch", i), 32'(log_ch[b_v]), 32'(vt[i].ch));
            check($sformatf("vec%0d_res_data", i), 32'(log_data[b_v]), 32'(vt[i].val));
            check($sformatf("vec%0d_req_count", i), 32'(n_req - b_r), 32'(NS));
            check($sformatf("vec%0d_vsenctl", i), 32'(log_vsen[b_r]), 32'(vt[i].ch));
            check($sformatf("vec%0d_adc_mode", i), 32'(log_mode[b_r]), 32'(vt[i].mode));
            check($sformatf("vec%0d_done_count", i), 32'(n_done - b_d), 32'd1);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            rd_ch = vt[i].ch;
            #1;
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vt[i].val));
            if (i == 0) check("rdy_to_valid_latency", 32'(valid_t - rdy_t), 32'd30);
        end
        rd_ch = 3'd6;
        #1;
        check("rd_ch6_reads_zero", 32'(rd_data), 32'd0);
        rd_ch = 3'd7;
        #1;
        check("rd_ch7_reads_zero", 32'(rd_data), 32'd0);

        // Two-channel scan; bank read shows old value until the write edge
        model_val[0] = 14'h1234;
        model_val[2] = 14'h0ABC;
        ch_mask = 6'h05;
        temp_mask = 6'h00;
        rd_ch = 3'd0;
        b_v = n_valid; b_r = n_req; b_d = n_done;
        pulse_start();
        k = 0;
        prev_rd = rd_data;
        while (!scan_done && k < 800) begin
            @(negedge clk);
            if (res_valid && res_ch == 3'd0) begin
                check("same_cycle_read_old", 32'(prev_rd), 32'h1555);
                check("after_write_read_new", 32'(rd_data), 32'h1234);
            end
            prev_rd = rd_data;
            k++;
        end
        check("two_ch_done_in_time", 32'(k < 800), 32'd1);
        repeat (5) @(negedge clk);
        check("two_ch_valid_count", 32'(n_valid - b_v), 32'd2);
        check("two_ch_first_ch", 32'(log_ch[b_v]), 32'd0);
        check("two_ch_second_ch", 32'(log_ch[b_v + 1]), 32'd2);
        check("two_ch_first_data", 32'(log_data[b_v]), 32'h1234);
        check("two_ch_second_data", 32'(log_data[b_v + 1]), 32'h0ABC);
        check("two_ch_vsen_first", 32'(log_vsen[b_r]), 32'd0);
        check("two_ch_vsen_second", 32'(log_vsen[b_r + NS]), 32'd2);
        check("two_ch_done_count", 32'(n_done - b_d), 32'd1);
        rd_ch = 3'd2;
        #1;
        check("two_ch_rd_data_ch2", 32'(rd_data), 32'h0ABC);

        // Timeout on ch1
        model_on = 0;
        ch_mask = 6'h02;
        b_v = n_valid; b_d = n_done;
        pulse_start();
        k = 0;
        while (!ifc.adc_req && k < 50) begin @(negedge clk); k++; end
        check("timeout_req_seen", 32'(k < 50), 32'd1);
        c = 0;
        while (ifc.adc_req && c < 200) begin c++; @(negedge clk); end
        check("timeout_req_cycles", 32'(c), 32'd40);
        wait_done("timeout_done_in_time", 50);
        repeat (3) @(negedge clk);
        check("timeout_err_flag", 32'(timeout_err), 32'h02);
        check("timeout_no_result", 32'(n_valid - b_v), 32'd0);
        check("timeout_done_count", 32'(n_done - b_d), 32'd1);
        rd_ch = 3'd1;
        #1;
        check("timeout_bank_kept", 32'(rd_data), 32'h0777);

        // Next scan start clears timeout_err
        model_on = 1;
        ch_mask = 6'h01;
        pulse_start();
        check("timeout_cleared_at_start", 32'(timeout_err), 32'd0);
        wait_done("clear_scan_done_in_time", 400);

        // Continuous mode, three scans then en low during SETTLE
        repeat (2) @(negedge clk);
        b_d = n_done;
        cont = 1'b1;
        nd = 0;
        k = 0;
        while (nd < 3 && k < 2000) begin
            @(negedge clk);
            if (scan_done) nd++;
            k++;
        end
        check("cont_three_scans", 32'(nd), 32'd3);
        repeat (3) @(negedge clk);
        check("cont_busy_in_settle", 32'(busy), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_low_busy", 32'(busy), 32'd0);
        check("en_low_req", 32'(ifc.adc_req), 32'd0);
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.adc_req || scan_done) c++;
        end
        check("en_low_no_activity", 32'(c), 32'd0);
        check("en_low_done_count", 32'(n_done - b_d), 32'd3);
        check("en_low_adc_en", 32'(ifc.adc_en), 32'd0);
        cont = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("reenable_stays_idle", 32'(busy), 32'd0);

        // start while busy is ignored; zero-mask start finishes next cycle
        ch_mask = 6'h01;
        b_v = n_valid; b_r = n_req; b_d = n_done;
        pulse_start();
        repeat (2) @(negedge clk);
        ch_mask = 6'h04;
        pulse_start();
        wait_done("busy_start_done_in_time", 400);
        repeat (5) @(negedge clk);
        check("busy_start_valid_count", 32'(n_valid - b_v), 32'd1);
        check("busy_start_res_ch", 32'(log_ch[b_v]), 32'd0);
        check("busy_start_req_count", 32'(n_req - b_r), 32'(NS));
        check("busy_start_done_count", 32'(n_done - b_d), 32'd1);
        ch_mask = '0;
        b_r = n_req;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_mask_done_pulse", 32'(scan_done), 32'd1);
        check("zero_mask_not_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("zero_mask_done_one_cycle", 32'(scan_done), 32'd0);
        repeat (10) @(negedge clk);
        check("zero_mask_no_req", 32'(n_req - b_r), 32'd0);

        // Reset during REQ, then an adcrdy glitch
        model_on = 0;
        ch_mask = 6'h08;
        pulse_start();
        k = 0;
        while (!ifc.adc_req && k < 50) begin @(negedge clk); k++; end
        check("rst_test_req_seen", 32'(k < 50), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        rd_ch = 3'd3;
        #1;
        check("midrst_req", 32'(ifc.adc_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mode", 32'(ifc.adc_mode), 32'd1);
        check("midrst_vsenctl", 32'(ifc.adc_vsenctl), 32'd0);
        check("midrst_adc_en", 32'(ifc.adc_en), 32'd0);
        check("midrst_bank_ch3", 32'(rd_data), 32'd0);
        rd_ch = 3'd4;
        #1;
        check("midrst_bank_ch4", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_v = n_valid; b_d = n_done;
        glitch_req++;
        repeat (20) @(negedge clk);
        check("glitch_no_result", 32'(n_valid - b_v), 32'd0);
        check("glitch_no_done", 32'(n_done - b_d), 32'd0);
        check("glitch_bank_zero", 32'(rd_data), 32'd0);
        check("post_rst_adc_en", 32'(ifc.adc_en), 32'd1);

`ifdef ADC_SCAN_AVG_EN
        // Averaging of four samples on ch3
        model_on = 1;
        seq[0] = 14'd100; seq[1] = 14'd101; seq[2] = 14'd102; seq[3] = 14'd103;
        seq_base = pulses;
        seq_len = 4;
        ch_mask = 6'h08;
        b_v = n_valid; b_r = n_req;
        pulse_start();
        wait_done("avg_done_in_time", 600);
        repeat (3) @(negedge clk);
        check("avg_valid_count", 32'(n_valid - b_v), 32'd1);
        check("avg_res_data", 32'(log_data[b_v]), 32'd101);
        check("avg_req_count", 32'(n_req - b_r), 32'd4);
        rd_ch = 3'd3;
        #1;
        check("avg_rd_data", 32'(rd_data), 32'd101);
        seq_len = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
